// File: rtl/width_conv_pkg.sv
// ----------------------------------------------------------------------------
// width_conv_pkg
// Shared types and helpers for the byte-lane width converters (8-to-16 packer
// and 16-to-8 serializer).
//   state_t     : serializer FSM states (IDLE, FIRST, SECOND)
//   IN_W/OUT_W  : word and byte widths
//   selectByte  : picks the half of a word that goes out on a given beat
// ----------------------------------------------------------------------------
package width_conv_pkg;

    localparam int IN_W  = 16;
    localparam int OUT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    // The upper half goes out when exactly one of (msbFirst, secondBeat) is
    // set: MSB-first sends upper then lower, LSB-first sends lower then upper.
    function automatic logic [OUT_W-1:0] selectByte(
        input logic [IN_W-1:0] word,
        input logic            msbFirst,
        input logic            secondBeat
    );
        return (msbFirst ^ secondBeat) ? word[IN_W-1:OUT_W] : word[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/width_16to8.sv
// ----------------------------------------------------------------------------
// width_16to8
// Serializes each accepted 16-bit word into two 8-bit beats with valid/ready
// handshakes on both sides. It sustains one byte per clock: the next word is
// taken on the same edge that the current word's second byte leaves.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   valid_in  : upstream word valid
//   data_in   : upstream word
//   ready_in  : block can accept a word this cycle (combinational)
//   valid_out : data_out holds a valid byte (registered)
//   data_out  : output byte (registered)
//   last_out  : high on the second byte of a word (registered)
//   ready_out : downstream accepts the byte this cycle
// Parameter MSB_FIRST: 1 sends [15:8] first, 0 sends [7:0] first.
// ----------------------------------------------------------------------------
module width_16to8
    import width_conv_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [IN_W-1:0]  data_in,
    output logic             ready_in,
    output logic             valid_out,
    output logic [OUT_W-1:0] data_out,
    output logic             last_out,
    input  logic             ready_out
);

    state_t             r_state;
    logic [IN_W-1:0]    r_word;
    logic [OUT_W-1:0]   r_dataOut;
    logic               r_validOut;
    logic               r_lastOut;

    state_t             w_nextState;
    logic [IN_W-1:0]    w_nextWord;
    logic [OUT_W-1:0]   w_nextData;
    logic               w_nextValid;
    logic               w_nextLast;
    logic               w_inXfer;
    logic               w_outXfer;

    // A word can be taken when idle, or when the second byte is leaving on
    // this very edge; that overlap is what removes the bubble between words.
    assign ready_in  = (r_state == IDLE) || ((r_state == SECOND) && ready_out);
    assign w_inXfer  = valid_in && ready_in;
    assign w_outXfer = r_validOut && ready_out;

    assign valid_out = r_validOut;
    assign data_out  = r_dataOut;
    assign last_out  = r_lastOut;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and next-output logic. Everything holds by default, which
    // keeps data_out/last_out stable while a presented byte is stalled.
    always_comb begin
        w_nextState = r_state;
        w_nextWord  = r_word;
        w_nextData  = r_dataOut;
        w_nextValid = r_validOut;
        w_nextLast  = r_lastOut;
        case (r_state)
            IDLE: begin
                if (w_inXfer) begin
                    w_nextWord  = data_in;
                    w_nextData  = selectByte(data_in, MSB_FIRST, 1'b0);
                    w_nextValid = 1'b1;
                    w_nextLast  = 1'b0;
                    w_nextState = FIRST;
                end
            end
            FIRST: begin
                if (w_outXfer) begin
                    w_nextData  = selectByte(r_word, MSB_FIRST, 1'b1);
                    w_nextLast  = 1'b1;
                    w_nextState = SECOND;
                end
            end
            SECOND: begin
                if (w_outXfer) begin
                    if (w_inXfer) begin
                        w_nextWord  = data_in;
                        w_nextData  = selectByte(data_in, MSB_FIRST, 1'b0);
                        w_nextLast  = 1'b0;
                        w_nextState = FIRST;
                    end else begin
                        w_nextValid = 1'b0;
                        w_nextLast  = 1'b0;
                        w_nextState = IDLE;
                    end
                end
            end
            default: begin
                w_nextValid = 1'b0;
                w_nextLast  = 1'b0;
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word     <= '0;
            r_dataOut  <= '0;
            r_validOut <= 1'b0;
            r_lastOut  <= 1'b0;
        end else begin
            r_word     <= w_nextWord;
            r_dataOut  <= w_nextData;
            r_validOut <= w_nextValid;
            r_lastOut  <= w_nextLast;
        end
    end

endmodule

// File: tb/tb_width_16to8.sv
// ----------------------------------------------------------------------------
// tb_width_16to8
// Drives an MSB-first and an LSB-first instance with the same handshake
// stimulus. A byte-queue model predicts every output each cycle; directed
// literal checks pin the model to hand-computed byte sequences.
// ----------------------------------------------------------------------------
module tb_width_16to8;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [15:0] data_in;
    logic        ready_out;

    logic        readyInA,  readyInB;
    logic        validOutA, validOutB;
    logic [7:0]  dataOutA,  dataOutB;
    logic        lastOutA,  lastOutB;

    int total = 0;
    int bad   = 0;

    // Model: bytes still owed downstream, head is what must be presented.
    logic [7:0] qA[$];
    logic [7:0] qB[$];
    logic [7:0] shownA = 8'h00;
    logic [7:0] shownB = 8'h00;
    bit         mAccept;
    bit         checkEnable = 1'b0;

    width_16to8 #(.MSB_FIRST(1'b1)) dutA (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_in  (readyInA),
        .valid_out (validOutA),
        .data_out  (dataOutA),
        .last_out  (lastOutA),
        .ready_out (ready_out)
    );

    width_16to8 #(.MSB_FIRST(1'b0)) dutB (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_in  (readyInB),
        .valid_out (validOutB),
        .data_out  (dataOutB),
        .last_out  (lastOutB),
        .ready_out (ready_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it if it fails.
    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Sets the inputs, then returns just after the edge that consumed them.
    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic r);
        valid_in  = v;
        data_in   = d;
        ready_out = r;
        @(posedge clk);
        #1;
    endtask

    // Model update: a byte leaves when presented and ready_out is high; a word
    // is taken when nothing is owed, or only its predecessor's last byte is
    // owed and that byte is leaving now.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qA.delete();
            qB.delete();
            shownA = 8'h00;
            shownB = 8'h00;
        end else begin
            mAccept = valid_in && ((qA.size() == 0) || ((qA.size() == 1) && ready_out));
            if ((qA.size() > 0) && ready_out) begin
                void'(qA.pop_front());
                void'(qB.pop_front());
            end
            if (mAccept) begin
                qA.push_back(data_in[15:8]);
                qA.push_back(data_in[7:0]);
                qB.push_back(data_in[7:0]);
                qB.push_back(data_in[15:8]);
            end
            if (qA.size() > 0) begin
                shownA = qA[0];
                shownB = qB[0];
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checkEnable) begin
            checkOutput("A.valid_out", {15'd0, validOutA}, {15'd0, qA.size() != 0});
            checkOutput("A.last_out",  {15'd0, lastOutA},  {15'd0, qA.size() == 1});
            checkOutput("A.data_out",  {8'd0, dataOutA},   {8'd0, shownA});
            checkOutput("A.ready_in",  {15'd0, readyInA},
                        {15'd0, (qA.size() == 0) || ((qA.size() == 1) && ready_out)});
            checkOutput("B.valid_out", {15'd0, validOutB}, {15'd0, qB.size() != 0});
            checkOutput("B.last_out",  {15'd0, lastOutB},  {15'd0, qB.size() == 1});
            checkOutput("B.data_out",  {8'd0, dataOutB},   {8'd0, shownB});
            checkOutput("B.ready_in",  {15'd0, readyInB},
                        {15'd0, (qB.size() == 0) || ((qB.size() == 1) && ready_out)});
        end
    end

    initial begin
        rst_n     = 1'b0;
        valid_in  = 1'b0;
        data_in   = 16'h0000;
        ready_out = 1'b0;
        $display("[TB] start");

        // Reset with random inputs: outputs must stay at reset values.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            valid_in  = 1'($urandom_range(0, 1));
            data_in   = 16'($urandom);
            ready_out = 1'($urandom_range(0, 1));
            checkEnable = 1'b1;
        end
        #1;
        checkOutput("rst.valid_out", {15'd0, validOutA}, 16'd0);
        checkOutput("rst.data_out",  {8'd0, dataOutA},   16'd0);
        checkOutput("rst.last_out",  {15'd0, lastOutA},  16'd0);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        rst_n    = 1'b1;
        #1;
        checkOutput("rst.ready_in", {15'd0, readyInA}, 16'd1);
        @(posedge clk);
        #1;

        // Single word A55A.
        applyStimulus(1'b1, 16'hA55A, 1'b1);
        checkOutput("single.A.byte0", {7'd0, validOutA, dataOutA}, 16'h01A5);
        checkOutput("single.A.last0", {15'd0, lastOutA}, 16'd0);
        checkOutput("single.B.byte0", {8'd0, dataOutB}, 16'h005A);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("single.A.byte1", {7'd0, validOutA, dataOutA}, 16'h015A);
        checkOutput("single.A.last1", {15'd0, lastOutA}, 16'd1);
        checkOutput("single.B.byte1", {8'd0, dataOutB}, 16'h00A5);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("single.A.idle", {15'd0, validOutA}, 16'd0);

        // Back-to-back stream 1234, 5678, 9ABC.
        applyStimulus(1'b1, 16'h1234, 1'b1);
        checkOutput("b2b.0", {7'd0, lastOutA, dataOutA}, 16'h0012);
        applyStimulus(1'b1, 16'h5678, 1'b1);
        checkOutput("b2b.1", {7'd0, lastOutA, dataOutA}, 16'h0134);
        applyStimulus(1'b1, 16'h5678, 1'b1);
        checkOutput("b2b.2", {7'd0, lastOutA, dataOutA}, 16'h0056);
        applyStimulus(1'b1, 16'h9ABC, 1'b1);
        checkOutput("b2b.3", {7'd0, lastOutA, dataOutA}, 16'h0178);
        applyStimulus(1'b1, 16'h9ABC, 1'b1);
        checkOutput("b2b.4", {7'd0, lastOutA, dataOutA}, 16'h009A);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("b2b.5", {7'd0, lastOutA, dataOutA}, 16'h01BC);
        checkOutput("b2b.5.valid", {15'd0, validOutA}, 16'd1);
        applyStimulus(1'b0, 16'h0000, 1'b1);

        // Backpressure on EF while CAFE waits.
        applyStimulus(1'b1, 16'hBEEF, 1'b1);
        checkOutput("bp.BE", {8'd0, dataOutA}, 16'h00BE);
        applyStimulus(1'b1, 16'hCAFE, 1'b1);
        checkOutput("bp.EF", {7'd0, lastOutA, dataOutA}, 16'h01EF);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'hCAFE, 1'b0);
            checkOutput("bp.hold", {6'd0, validOutA, lastOutA, dataOutA}, 16'h03EF);
            checkOutput("bp.ready_in", {15'd0, readyInA}, 16'd0);
        end
        applyStimulus(1'b1, 16'hCAFE, 1'b1);
        checkOutput("bp.CA", {7'd0, lastOutA, dataOutA}, 16'h00CA);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("bp.FE", {7'd0, lastOutA, dataOutA}, 16'h01FE);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("bp.idle", {15'd0, validOutA}, 16'd0);

        // Reset in the middle of 1234.
        applyStimulus(1'b1, 16'h1234, 1'b1);
        checkOutput("mid.12", {8'd0, dataOutA}, 16'h0012);
        valid_in  = 1'b0;
        ready_out = 1'b0;
        rst_n     = 1'b0;
        #1;
        checkOutput("mid.clear", {6'd0, validOutA, lastOutA, dataOutA}, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 16'h00FF, 1'b1);
        checkOutput("mid.00", {6'd0, validOutA, lastOutA, dataOutA}, 16'h0200);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("mid.FF", {6'd0, validOutA, lastOutA, dataOutA}, 16'h03FF);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("mid.idle", {15'd0, validOutA}, 16'd0);

        @(posedge clk);
        #1;
        checkEnable = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
